// File: rtl/pipe_ctrl.sv
// Pipeline control: arbitrates jump/flush and hold/stall requests for the PC, IF/ID and ID/EX stages.
// Optional hold watchdog is compiled in with `define CTRL_HOLD_TIMEOUT_EN.
module pipe_ctrl #(
  parameter int unsigned FLUSH_CYCLES = 2,
  parameter int unsigned HOLD_TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        jump_en_i,
  input  logic [31:0] jump_addr_i,
  input  logic        hold_flag_i,
  input  logic        bus_hold_i,
  output logic        jump_en_o,
  output logic [31:0] jump_addr_o,
  output logic        flush_o,
  output logic        hold_o,
  output logic [15:0] jump_cnt_o,
  output logic        hold_timeout_o
);

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    HOLD
  } state_e;

  localparam logic [2:0] FLUSH_LOAD = 3'(FLUSH_CYCLES - 1);

  if (FLUSH_CYCLES < 1 || FLUSH_CYCLES > 7 || HOLD_TIMEOUT < 2 || HOLD_TIMEOUT > 255) begin : gBadParam
    $error("pipe_ctrl: FLUSH_CYCLES must be 1..7 and HOLD_TIMEOUT 2..255");
  end

  state_e      state_q;
  logic [2:0]  flushCnt_q;
  logic [15:0] jumpCnt_q;
  logic [15:0] jumpCnt_d;
  logic        jumpAccept;
  logic        holdReq;
  logic        holdMask;

  // Jumps from squashed instructions (state FLUSH) are never accepted.
  always_comb begin
    jumpAccept = 1'b0;
    holdReq    = 1'b0;
    if (!rst) begin
      jumpAccept = jump_en_i && (state_q != FLUSH);
      holdReq    = hold_flag_i | bus_hold_i;
    end
  end

  always_comb begin
    jump_en_o   = jumpAccept;
    jump_addr_o = jumpAccept ? jump_addr_i : 32'h0;
    flush_o     = !rst && (jumpAccept || (state_q == FLUSH));
    hold_o      = !rst && (state_q != FLUSH) && !jumpAccept && holdReq && !holdMask;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      flushCnt_q <= 3'd0;
    end else begin
      case (state_q)
        IDLE, HOLD: begin
          if (jumpAccept) begin
            flushCnt_q <= FLUSH_LOAD;
            state_q    <= (FLUSH_LOAD != 3'd0) ? FLUSH : IDLE;
          end else begin
            state_q <= hold_o ? HOLD : IDLE;
          end
        end
        FLUSH: begin
          flushCnt_q <= flushCnt_q - 3'd1;
          if (flushCnt_q <= 3'd1) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q    <= IDLE;
          flushCnt_q <= 3'd0;
        end
      endcase
    end
  end

  always_comb begin
    jumpCnt_d = jumpCnt_q;
    if (jumpAccept && (jumpCnt_q != 16'hFFFF)) begin
      jumpCnt_d = jumpCnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      jumpCnt_q <= 16'd0;
    end else begin
      jumpCnt_q <= jumpCnt_d;
    end
  end

  assign jump_cnt_o = jumpCnt_q;

`ifdef CTRL_HOLD_TIMEOUT_EN
  localparam logic [7:0] HOLD_LIMIT = 8'(HOLD_TIMEOUT - 1);

  logic [7:0] holdCnt_q;
  logic [7:0] holdCnt_d;
  logic       release_q;
  logic       release_d;
  logic       timeout_q;
  logic       timeout_d;

  // A release cycle drops hold_o for one cycle, which also clears the count.
  always_comb begin
    holdCnt_d = hold_o ? (holdCnt_q + 8'd1) : 8'd0;
    release_d = hold_o && (holdCnt_q == HOLD_LIMIT);
    timeout_d = timeout_q | release_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      holdCnt_q <= 8'd0;
      release_q <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      holdCnt_q <= holdCnt_d;
      release_q <= release_d;
      timeout_q <= timeout_d;
    end
  end

  assign holdMask       = release_q;
  assign hold_timeout_o = !rst && (timeout_q || release_q);
`else
  assign holdMask       = 1'b0;
  assign hold_timeout_o = 1'b0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl: reset, jump/flush, hold, watchdog and counter saturation.
// Watchdog expectations follow whether CTRL_HOLD_TIMEOUT_EN is defined for the build.
module tb_pipe_ctrl;

  logic        clk;
  logic        rst;
  logic        jumpEn;
  logic [31:0] jumpAddr;
  logic        holdFlag;
  logic        busHold;

  logic        aJumpEn, wJumpEn, sJumpEn;
  logic [31:0] aJumpAddr, wJumpAddr, sJumpAddr;
  logic        aFlush, wFlush, sFlush;
  logic        aHold, wHold, sHold;
  logic [15:0] aCnt, wCnt, sCnt;
  logic        aTo, wTo, sTo;

  int testCount = 0;
  int failCount = 0;

  logic [9:0] expHold;
  logic [9:0] expTo;

  pipe_ctrl #(.FLUSH_CYCLES(2), .HOLD_TIMEOUT(16)) dutA (
    .clk(clk), .rst(rst), .jump_en_i(jumpEn), .jump_addr_i(jumpAddr),
    .hold_flag_i(holdFlag), .bus_hold_i(busHold), .jump_en_o(aJumpEn),
    .jump_addr_o(aJumpAddr), .flush_o(aFlush), .hold_o(aHold),
    .jump_cnt_o(aCnt), .hold_timeout_o(aTo)
  );

  pipe_ctrl #(.FLUSH_CYCLES(2), .HOLD_TIMEOUT(4)) dutW (
    .clk(clk), .rst(rst), .jump_en_i(jumpEn), .jump_addr_i(jumpAddr),
    .hold_flag_i(holdFlag), .bus_hold_i(busHold), .jump_en_o(wJumpEn),
    .jump_addr_o(wJumpAddr), .flush_o(wFlush), .hold_o(wHold),
    .jump_cnt_o(wCnt), .hold_timeout_o(wTo)
  );

  pipe_ctrl #(.FLUSH_CYCLES(1), .HOLD_TIMEOUT(16)) dutS (
    .clk(clk), .rst(rst), .jump_en_i(jumpEn), .jump_addr_i(jumpAddr),
    .hold_flag_i(holdFlag), .bus_hold_i(busHold), .jump_en_o(sJumpEn),
    .jump_addr_o(sJumpAddr), .flush_o(sFlush), .hold_o(sHold),
    .jump_cnt_o(sCnt), .hold_timeout_o(sTo)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic applyStimulus(input logic r, input logic je, input logic [31:0] ja,
                               input logic hf, input logic bh);
    rst      = r;
    jumpEn   = je;
    jumpAddr = ja;
    holdFlag = hf;
    busHold  = bh;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    testCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Inputs change #1 after a rising edge; outputs are checked on the falling edge.
  task automatic nextCycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    applyStimulus(1'b1, 1'b1, 32'h0000_1234, 1'b1, 1'b1);

    // Reset dominates active jump and hold requests.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("rst jump_en_o", {31'd0, aJumpEn}, 32'd0);
      checkOutput("rst jump_addr_o", aJumpAddr, 32'd0);
      checkOutput("rst flush_o", {31'd0, aFlush}, 32'd0);
      checkOutput("rst hold_o", {31'd0, aHold}, 32'd0);
      checkOutput("rst jump_cnt_o", {16'd0, aCnt}, 32'd0);
      checkOutput("rst hold_timeout_o", {31'd0, wTo}, 32'd0);
      nextCycle();
    end

    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle flush_o", {31'd0, aFlush}, 32'd0);
    checkOutput("idle hold_o", {31'd0, aHold}, 32'd0);
    checkOutput("idle jump_cnt_o", {16'd0, aCnt}, 32'd0);
    nextCycle();

    // Single jump: two flush cycles, count becomes 1.
    applyStimulus(1'b0, 1'b1, 32'h0000_0100, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("jump jump_en_o", {31'd0, aJumpEn}, 32'd1);
    checkOutput("jump jump_addr_o", aJumpAddr, 32'h0000_0100);
    checkOutput("jump flush_o c1", {31'd0, aFlush}, 32'd1);
    checkOutput("jump hold_o", {31'd0, aHold}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("jump flush_o c2", {31'd0, aFlush}, 32'd1);
    checkOutput("jump jump_en_o c2", {31'd0, aJumpEn}, 32'd0);
    checkOutput("jump jump_cnt_o", {16'd0, aCnt}, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("jump flush_o c3", {31'd0, aFlush}, 32'd0);
    nextCycle();

    // Second jump and a hold request during flush are ignored.
    applyStimulus(1'b0, 1'b1, 32'h0000_0180, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("jflush first jump_en_o", {31'd0, aJumpEn}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b1, 32'h0000_0200, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("jflush jump_en_o", {31'd0, aJumpEn}, 32'd0);
    checkOutput("jflush jump_addr_o", aJumpAddr, 32'd0);
    checkOutput("jflush flush_o c2", {31'd0, aFlush}, 32'd1);
    checkOutput("jflush hold_o", {31'd0, aHold}, 32'd0);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("jflush flush_o c3", {31'd0, aFlush}, 32'd0);
    checkOutput("jflush jump_cnt_o", {16'd0, aCnt}, 32'd2);
    nextCycle();

    // Bus hold for five cycles, released in the sixth.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("hold hold_o", {31'd0, aHold}, 32'd1);
      checkOutput("hold flush_o", {31'd0, aFlush}, 32'd0);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("hold release hold_o", {31'd0, aHold}, 32'd0);
    nextCycle();

    // Jump in the third hold cycle pre-empts the stall.
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      checkOutput("hjump pre hold_o", {31'd0, aHold}, 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b1, 32'h0000_0300, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("hjump hold_o", {31'd0, aHold}, 32'd0);
    checkOutput("hjump flush_o", {31'd0, aFlush}, 32'd1);
    checkOutput("hjump jump_en_o", {31'd0, aJumpEn}, 32'd1);
    checkOutput("hjump jump_addr_o", aJumpAddr, 32'h0000_0300);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b1);
    @(negedge clk);
    checkOutput("hjump flush2 hold_o", {31'd0, aHold}, 32'd0);
    checkOutput("hjump flush2 flush_o", {31'd0, aFlush}, 32'd1);
    nextCycle();
    @(negedge clk);
    checkOutput("hjump after hold_o", {31'd0, aHold}, 32'd1);
    checkOutput("hjump after flush_o", {31'd0, aFlush}, 32'd0);
    checkOutput("hjump jump_cnt_o", {16'd0, aCnt}, 32'd3);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    nextCycle();

    // Mid-hold reset aborts; watchdog instance starts clean.
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b1, 1'b0);
    @(negedge clk);
    checkOutput("wd rst hold_o", {31'd0, wHold}, 32'd0);
    nextCycle();

`ifdef CTRL_HOLD_TIMEOUT_EN
    expHold = 10'b0111101111;
    expTo   = 10'b1111110000;
`else
    expHold = 10'b1111111111;
    expTo   = 10'b0000000000;
`endif
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput($sformatf("wd hold_o c%0d", i + 1), {31'd0, wHold}, {31'd0, expHold[i]});
      checkOutput($sformatf("wd hold_timeout_o c%0d", i + 1), {31'd0, wTo}, {31'd0, expTo[i]});
      checkOutput($sformatf("wd long-limit hold_o c%0d", i + 1), {31'd0, aHold}, 32'd1);
      nextCycle();
    end
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("wd sticky hold_timeout_o", {31'd0, wTo}, {31'd0, expTo[9]});
    checkOutput("wd idle hold_o", {31'd0, wHold}, 32'd0);
    nextCycle();
    applyStimulus(1'b1, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("wd rst hold_timeout_o", {31'd0, wTo}, 32'd0);
    nextCycle();

    // Back-to-back jumps on the single-flush instance drive the counter to saturation.
    applyStimulus(1'b0, 1'b1, 32'h0000_0ABC, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sat start jump_cnt_o", {16'd0, sCnt}, 32'd0);
    repeat (65534) @(posedge clk);
    #1;
    @(negedge clk);
    checkOutput("sat jump_cnt_o FFFE", {16'd0, sCnt}, 32'h0000_FFFE);
    nextCycle();
    @(negedge clk);
    checkOutput("sat jump_cnt_o FFFF", {16'd0, sCnt}, 32'h0000_FFFF);
    nextCycle();
    @(negedge clk);
    checkOutput("sat jump_en_o", {31'd0, sJumpEn}, 32'd1);
    nextCycle();
    applyStimulus(1'b0, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("sat no wrap jump_cnt_o", {16'd0, sCnt}, 32'h0000_FFFF);
    checkOutput("sat flush_o", {31'd0, sFlush}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
